// File: rtl/snn_axi_lite_master.sv
// snn_axi_lite_master: command/response stream to single-beat AXI4-Lite master, Rev 1.0
// Optional hardware poll-until-match enabled by defining SNN_AXI_MASTER_POLL_EN.
`default_nettype none

module snn_axi_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int POLL_MAX_BITS      = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic                            cmd_poll,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_mask,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_WB       = 3'd2,
        ST_RD_A     = 3'd3,
        ST_RD_D     = 3'd4,
        ST_POLL_CHK = 3'd5,
        ST_RSP      = 3'd6
    } state_t;

    state_t                          state;
    state_t                          state_next;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata;
    logic [STRB_W-1:0]               wstrb;
    logic                            aw_done;
    logic                            w_done;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      resp;
    logic                            accept;

    assign accept = (state == ST_IDLE) && cmd_valid;

`ifdef SNN_AXI_MASTER_POLL_EN
    localparam logic [POLL_MAX_BITS-1:0] POLL_MAX = {POLL_MAX_BITS{1'b1}};

    logic                            poll;
    logic [C_M_AXI_DATA_WIDTH-1:0]   mask;
    logic [POLL_MAX_BITS-1:0]        poll_cnt;
    logic                            timeout;
    logic                            poll_match;

    assign poll_match  = (rdata & mask) == (wdata & mask);
    assign rsp_timeout = timeout;

    // poll_cnt holds the number of completed read beats of the current command
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            poll     <= 1'b0;
            mask     <= '0;
            poll_cnt <= '0;
            timeout  <= 1'b0;
        end else if (accept) begin
            poll     <= cmd_poll && !cmd_write;
            mask     <= cmd_mask;
            poll_cnt <= '0;
            timeout  <= 1'b0;
        end else if (state == ST_RD_D && M_AXI_RVALID) begin
            poll_cnt <= poll_cnt + 1'b1;
        end else if (state == ST_POLL_CHK && !poll_match && poll_cnt == POLL_MAX) begin
            timeout  <= 1'b1;
        end
    end
`else
    localparam int unused_poll_bits = POLL_MAX_BITS;
    logic unused_poll_inputs;

    assign unused_poll_inputs = ^{cmd_poll, cmd_mask};
    assign rsp_timeout        = 1'b0;
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = cmd_write ? ST_WR : ST_RD_A;
                end
            end
            ST_WR: begin
                // A channel is finished once it has handshaken, now or earlier
                if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                if (M_AXI_BVALID) begin
                    state_next = ST_RSP;
                end
            end
            ST_RD_A: begin
                if (M_AXI_ARREADY) begin
                    state_next = ST_RD_D;
                end
            end
            ST_RD_D: begin
                if (M_AXI_RVALID) begin
`ifdef SNN_AXI_MASTER_POLL_EN
                    state_next = (poll && M_AXI_RRESP == 2'b00) ? ST_POLL_CHK : ST_RSP;
`else
                    state_next = ST_RSP;
`endif
                end
            end
`ifdef SNN_AXI_MASTER_POLL_EN
            ST_POLL_CHK: begin
                state_next = (poll_match || poll_cnt == POLL_MAX) ? ST_RSP : ST_RD_A;
            end
`endif
            ST_RSP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready     = (state == ST_IDLE);
        busy          = (state != ST_IDLE);
        rsp_valid     = (state == ST_RSP);
        M_AXI_AWVALID = (state == ST_WR) && !aw_done;
        M_AXI_WVALID  = (state == ST_WR) && !w_done;
        M_AXI_BREADY  = (state == ST_WB);
        M_AXI_ARVALID = (state == ST_RD_A);
        M_AXI_RREADY  = (state == ST_RD_D);
    end

    assign M_AXI_AWADDR = addr;
    assign M_AXI_ARADDR = addr;
    assign M_AXI_WDATA  = wdata;
    assign M_AXI_WSTRB  = wstrb;
    assign rsp_rdata    = rdata;
    assign rsp_resp     = resp;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            addr    <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata   <= '0;
            resp    <= 2'b00;
        end else begin
            if (accept) begin
                addr    <= cmd_addr;
                wdata   <= cmd_wdata;
                wstrb   <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                rdata   <= '0;
                resp    <= 2'b00;
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_done <= 1'b1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_done <= 1'b1;
            end
            if (M_AXI_BREADY && M_AXI_BVALID) begin
                resp <= M_AXI_BRESP;
            end
            if (M_AXI_RREADY && M_AXI_RVALID) begin
                rdata <= M_AXI_RDATA;
                resp  <= M_AXI_RRESP;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_snn_axi_lite_master.sv
// tb_snn_axi_lite_master: directed self-checking bench for snn_axi_lite_master.
// The slave model updates its inputs on the falling edge; the DUT samples them on the rising edge.
`default_nettype none

module tb_snn_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write, cmd_poll;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata, cmd_mask;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    snn_axi_lite_master #(
        .C_M_AXI_ADDR_WIDTH(16),
        .C_M_AXI_DATA_WIDTH(32),
        .POLL_MAX_BITS(3)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_poll(cmd_poll),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Slave configuration and observation counters
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;
    int          poll_clear_at = 0;
    bit          aw_got, w_got, r_pend, p_aw, p_w, p_b, p_ar, p_r;
    int          aw_vcycles, w_vcycles, aw_count, w_count, b_count, ar_count;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_got = 0; w_got = 0; r_pend = 0;
            p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0;
        end else begin
            if (p_aw) aw_got = 1;
            if (p_w)  w_got  = 1;
            if (p_b)  begin aw_got = 0; w_got = 0; end
            if (p_ar) r_pend = 1;
            if (p_r)  r_pend = 0;
            if (awvalid) begin
                aw_vcycles++;
                awready = (aw_wait >= aw_delay);
                if (!awready) aw_wait++;
            end else begin
                awready = 0; aw_wait = 0;
            end
            if (wvalid) begin
                w_vcycles++;
                wready = (w_wait >= w_delay);
                if (!wready) w_wait++;
            end else begin
                wready = 0; w_wait = 0;
            end
            if (arvalid) begin
                arready = (ar_wait >= ar_delay);
                if (!arready) ar_wait++;
            end else begin
                arready = 0; ar_wait = 0;
            end
            bvalid = aw_got && w_got;
            bresp  = bvalid ? bresp_cfg : 2'b00;
            rvalid = r_pend;
            rresp  = rvalid ? rresp_cfg : 2'b00;
            if (poll_clear_at != 0) rdata = (ar_count >= poll_clear_at) ? 32'h0 : 32'h1;
            else                    rdata = rdata_cfg;
            p_aw = awvalid && awready;
            p_w  = wvalid && wready;
            p_b  = bvalid && bready;
            p_ar = arvalid && arready;
            p_r  = rvalid && rready;
            if (p_aw) aw_count++;
            if (p_w)  w_count++;
            if (p_b)  b_count++;
            if (p_ar) ar_count++;
        end
    end

    // Snapshot of the master outputs one step after the accepting edge
    logic        snap_aw, snap_w, snap_ar;
    logic [15:0] snap_awaddr, snap_araddr;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_wstrb;

    task automatic clear_counts();
        aw_vcycles = 0; w_vcycles = 0; aw_count = 0; w_count = 0; b_count = 0; ar_count = 0;
    endtask

    // Issue one command, wait for its response and complete the response handshake.
    // lat counts rising edges from the accepting edge (inclusive) until rsp_valid is seen.
    task automatic do_cmd(input logic wr, input logic pl, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s, input logic [31:0] m,
                          output int lat, output logic [31:0] rd, output logic [1:0] rr,
                          output logic to, output logic ok);
        int n;
        @(negedge clk);
        cmd_write = wr; cmd_poll = pl; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_mask = m;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        snap_aw = awvalid; snap_w = wvalid; snap_ar = arvalid;
        snap_awaddr = awaddr; snap_araddr = araddr; snap_wdata = wdata; snap_wstrb = wstrb;
        lat = 1;
        while (!rsp_valid && lat < 400) begin @(posedge clk); #1; lat++; end
        ok = rsp_valid;
        rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        to, ok;

    task automatic test_reset();
        logic [31:0] outs;
        outs = {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, busy,
                rsp_resp, awaddr, 6'b0};
        tests_run++;
        if (outs !== 32'h0) begin tests_failed++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        tests_run++;
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        tests_run++;
        if (rsp_rdata !== 32'h0 || wdata !== 32'h0) begin tests_failed++;
            $display("FAIL reset_data: got rdata %h wdata %h expected 0", rsp_rdata, wdata); end
    endtask

    task automatic test_write_basic();
        aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00; clear_counts();
        do_cmd(1'b1, 1'b0, 16'h0010, 32'hA5A5_0001, 4'hF, 32'h0, lat, rd, rr, to, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL wr_rsp_timeout: got no rsp_valid expected rsp_valid"); end
        tests_run++;
        if ({snap_aw, snap_w} !== 2'b11) begin tests_failed++;
            $display("FAIL wr_aw_w_together: got %b expected 11", {snap_aw, snap_w}); end
        tests_run++;
        if (snap_awaddr !== 16'h0010 || snap_wdata !== 32'hA5A5_0001 || snap_wstrb !== 4'hF) begin tests_failed++;
            $display("FAIL wr_payload: got %h/%h/%h expected 0010/a5a50001/f", snap_awaddr, snap_wdata, snap_wstrb); end
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        tests_run++;
        if (rr !== 2'b00 || rd !== 32'h0) begin tests_failed++;
            $display("FAIL wr_rsp: got resp %b rdata %h expected 00 0", rr, rd); end
        tests_run++;
        if (b_count !== 1 || ar_count !== 0) begin tests_failed++;
            $display("FAIL wr_counts: got b %0d ar %0d expected 1 0", b_count, ar_count); end
    endtask

    task automatic test_write_aw_delay();
        aw_delay = 4; w_delay = 0; bresp_cfg = 2'b10; clear_counts();
        do_cmd(1'b1, 1'b0, 16'h0020, 32'h1234_5678, 4'h3, 32'h0, lat, rd, rr, to, ok);
        aw_delay = 0;
        tests_run++;
        if ({snap_aw, snap_w} !== 2'b11) begin tests_failed++;
            $display("FAIL wdly_together: got %b expected 11", {snap_aw, snap_w}); end
        // Four refused cycles plus the handshake cycle
        tests_run++;
        if (aw_vcycles !== 5 || w_vcycles !== 1) begin tests_failed++;
            $display("FAIL wdly_valid_cycles: got aw %0d w %0d expected 5 1", aw_vcycles, w_vcycles); end
        tests_run++;
        if (aw_count !== 1 || w_count !== 1 || b_count !== 1) begin tests_failed++;
            $display("FAIL wdly_handshakes: got aw %0d w %0d b %0d expected 1 1 1", aw_count, w_count, b_count); end
        tests_run++;
        if (lat !== 7) begin tests_failed++; $display("FAIL wdly_latency: got %0d expected 7", lat); end
        tests_run++;
        if (rr !== 2'b10) begin tests_failed++; $display("FAIL wdly_bresp: got %b expected 10", rr); end
    endtask

    task automatic test_read();
        rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b10; poll_clear_at = 0; clear_counts();
        do_cmd(1'b0, 1'b0, 16'h0004, 32'h0, 4'h0, 32'h0, lat, rd, rr, to, ok);
        tests_run++;
        if (snap_ar !== 1'b1 || snap_aw !== 1'b0 || snap_araddr !== 16'h0004) begin tests_failed++;
            $display("FAIL rd_ar: got arvalid %b awvalid %b araddr %h expected 1 0 0004", snap_ar, snap_aw, snap_araddr); end
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        tests_run++;
        if (rd !== 32'hDEAD_BEEF || rr !== 2'b10 || to !== 1'b0) begin tests_failed++;
            $display("FAIL rd_rsp: got %h %b %b expected deadbeef 10 0", rd, rr, to); end
        tests_run++;
        if (ar_count !== 1 || b_count !== 0) begin tests_failed++;
            $display("FAIL rd_counts: got ar %0d b %0d expected 1 0", ar_count, b_count); end
        rresp_cfg = 2'b00;
    endtask

    task automatic test_poll();
`ifdef SNN_AXI_MASTER_POLL_EN
        rresp_cfg = 2'b00; poll_clear_at = 5; clear_counts();
        do_cmd(1'b0, 1'b1, 16'h0008, 32'h0, 4'h0, 32'h1, lat, rd, rr, to, ok);
        tests_run++;
        if (ar_count !== 5 || to !== 1'b0 || rd !== 32'h0) begin tests_failed++;
            $display("FAIL poll_match: got ar %0d timeout %b rdata %h expected 5 0 0", ar_count, to, rd); end
        poll_clear_at = 0; rdata_cfg = 32'h1; clear_counts();
        do_cmd(1'b0, 1'b1, 16'h0008, 32'h0, 4'h0, 32'h1, lat, rd, rr, to, ok);
        tests_run++;
        if (ar_count !== 7 || to !== 1'b1 || rd !== 32'h1) begin tests_failed++;
            $display("FAIL poll_exhaust: got ar %0d timeout %b rdata %h expected 7 1 1", ar_count, to, rd); end
`else
        poll_clear_at = 0; rdata_cfg = 32'h1; rresp_cfg = 2'b00; clear_counts();
        do_cmd(1'b0, 1'b1, 16'h0008, 32'h0, 4'h0, 32'h1, lat, rd, rr, to, ok);
        tests_run++;
        if (ar_count !== 1 || to !== 1'b0 || rd !== 32'h1 || lat !== 3) begin tests_failed++;
            $display("FAIL poll_disabled: got ar %0d timeout %b rdata %h lat %0d expected 1 0 1 3", ar_count, to, rd, lat); end
`endif
    endtask

    task automatic test_poll_write();
        bresp_cfg = 2'b00; clear_counts();
        do_cmd(1'b1, 1'b1, 16'h0030, 32'h0000_00FF, 4'h1, 32'hFFFF_FFFF, lat, rd, rr, to, ok);
        tests_run++;
        if (b_count !== 1 || ar_count !== 0 || to !== 1'b0 || lat !== 3) begin tests_failed++;
            $display("FAIL poll_write: got b %0d ar %0d timeout %b lat %0d expected 1 0 0 3", b_count, ar_count, to, lat); end
    endtask

    task automatic test_back_to_back();
        int n;
        rdata_cfg = 32'h1234_ABCD; rresp_cfg = 2'b00; clear_counts();
        @(negedge clk);
        cmd_write = 1'b1; cmd_poll = 1'b0; cmd_addr = 16'h0040; cmd_wdata = 32'h5; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_write = 1'b0; cmd_addr = 16'h0044; cmd_valid = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin tests_failed++;
            $display("FAIL b2b_idle: got rsp_valid/busy/cmd_ready %b expected 001", {rsp_valid, busy, cmd_ready}); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tests_run++;
        if ({busy, arvalid, araddr} !== {2'b11, 16'h0044}) begin tests_failed++;
            $display("FAIL b2b_accept: got busy %b arvalid %b araddr %h expected 1 1 0044", busy, arvalid, araddr); end
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        tests_run++;
        if (rsp_rdata !== 32'h1234_ABCD || !rsp_valid) begin tests_failed++;
            $display("FAIL b2b_read: got %h valid %b expected 1234abcd 1", rsp_rdata, rsp_valid); end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] outs;
        ar_delay = 100; clear_counts();
        @(negedge clk);
        cmd_write = 1'b0; cmd_poll = 1'b0; cmd_addr = 16'h0050; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (arvalid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre: got arvalid %b expected 1", arvalid); end
        #2 rst_n = 1'b0;
        #1;
        outs = {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, busy, araddr, 8'b0};
        tests_run++;
        if (outs !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        ar_delay = 0;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, cmd_ready, arvalid} !== 3'b010) begin tests_failed++;
            $display("FAIL rst_mid_idle: got busy/cmd_ready/arvalid %b expected 010", {busy, cmd_ready, arvalid}); end
        rdata_cfg = 32'hCAFE_0042; clear_counts();
        do_cmd(1'b0, 1'b0, 16'h0054, 32'h0, 4'h0, 32'h0, lat, rd, rr, to, ok);
        tests_run++;
        if (rd !== 32'hCAFE_0042 || lat !== 3 || ar_count !== 1) begin tests_failed++;
            $display("FAIL rst_mid_recover: got %h lat %0d ar %0d expected cafe0042 3 1", rd, lat, ar_count); end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_poll = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; cmd_mask = '0; rsp_ready = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read();
        test_poll();
        test_poll_write();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
